// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM request port among NREQ DMA engines; 1-cycle arbitration, bursts capped at MAX_BURST, one read in flight.
// Stalls on ctrl_busy with req_busy held high. Define SDRAM_ARB_TIMEOUT_EN to add the read-wait watchdog.
module sdram_req_arbiter #(
    parameter int NREQ       = 3,
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 8,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_rw,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_busy,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   ctrl_in_valid,
    output logic                   ctrl_rw,
    output logic [ADDR_W-1:0]      ctrl_addr,
    output logic [DATA_W-1:0]      ctrl_wdata,
    input  logic                   ctrl_busy,
    input  logic                   ctrl_out_valid,
    input  logic [DATA_W-1:0]      ctrl_rdata,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RD_WAIT} state_t;

    localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

    state_t      r_state, w_next_state;
    logic [1:0]  r_gnt, w_next_gnt;
    logic [1:0]  r_last_gnt, w_next_last_gnt;
    logic [7:0]  r_burst_cnt, w_next_burst_cnt, w_burst_inc;
    logic [1:0]  w_c0, w_c1, w_c2, w_pick;
    logic        w_accept, w_rd_done, w_wd_fire;

    logic [ADDR_W-1:0] w_addr  [NREQ];
    logic [DATA_W-1:0] w_wdata [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    // Search order starts just after the last owner.
    always_comb begin
        w_c0 = 2'd0;
        w_c1 = 2'd1;
        w_c2 = 2'd2;
        case (r_last_gnt)
            2'd0:    begin w_c0 = 2'd1; w_c1 = 2'd2; w_c2 = 2'd0; end
            2'd1:    begin w_c0 = 2'd2; w_c1 = 2'd0; w_c2 = 2'd1; end
            default: begin w_c0 = 2'd0; w_c1 = 2'd1; w_c2 = 2'd2; end
        endcase
        w_pick = w_c2;
        if (req_valid[w_c1]) w_pick = w_c1;
        if (req_valid[w_c0]) w_pick = w_c0;
    end

    assign w_accept    = (r_state == S_GRANT) && req_valid[r_gnt] && !ctrl_busy;
    assign w_rd_done   = (r_state == S_RD_WAIT) && ctrl_out_valid;
    assign w_burst_inc = (r_burst_cnt < LP_MAX_BURST) ? r_burst_cnt + 8'd1 : r_burst_cnt;

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [7:0] r_wd_cnt;
    logic       r_timeout_err;

    assign w_wd_fire   = (r_state == S_RD_WAIT) && !ctrl_out_valid && (r_wd_cnt == 8'(RD_TIMEOUT));
    assign timeout_err = r_timeout_err;

    // Held at zero outside RD_WAIT, so it starts from zero on every entry.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_wd_cnt      <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wd_cnt <= (r_state == S_RD_WAIT) ? r_wd_cnt + 8'd1 : 8'd0;
            if (w_wd_fire) r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_wd_fire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_next_state     = r_state;
        w_next_gnt       = r_gnt;
        w_next_last_gnt  = r_last_gnt;
        w_next_burst_cnt = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_next_gnt       = w_pick;
                    w_next_burst_cnt = 8'd0;
                    w_next_state     = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req_valid[r_gnt]) begin
                    w_next_state    = S_IDLE;
                    w_next_last_gnt = r_gnt;
                end else if (!ctrl_busy) begin
                    w_next_burst_cnt = w_burst_inc;
                    if (!req_rw[r_gnt]) begin
                        w_next_state = S_RD_WAIT;
                    end else if (w_burst_inc == LP_MAX_BURST) begin
                        w_next_state    = S_IDLE;
                        w_next_last_gnt = r_gnt;
                    end
                end
            end
            S_RD_WAIT: begin
                if (w_rd_done) begin
                    if ((r_burst_cnt < LP_MAX_BURST) && req_valid[r_gnt]) begin
                        w_next_state = S_GRANT;
                    end else begin
                        w_next_state    = S_IDLE;
                        w_next_last_gnt = r_gnt;
                    end
                end else if (w_wd_fire) begin
                    w_next_state    = S_IDLE;
                    w_next_last_gnt = r_gnt;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state     <= S_IDLE;
            r_gnt       <= 2'd0;
            r_last_gnt  <= 2'd2;
            r_burst_cnt <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            r_gnt       <= w_next_gnt;
            r_last_gnt  <= w_next_last_gnt;
            r_burst_cnt <= w_next_burst_cnt;
        end
    end

    // Forwarded fields are zeroed outside GRANT so idle/reset outputs are clean.
    always_comb begin
        ctrl_in_valid = 1'b0;
        ctrl_rw       = 1'b0;
        ctrl_addr     = '0;
        ctrl_wdata    = '0;
        req_busy      = '1;
        rsp_valid     = '0;
        rsp_rdata     = '0;
        if (r_state == S_GRANT) begin
            ctrl_in_valid = req_valid[r_gnt];
            ctrl_rw       = req_rw[r_gnt];
            ctrl_addr     = w_addr[r_gnt];
            ctrl_wdata    = w_wdata[r_gnt];
        end
        if (w_accept) req_busy[r_gnt] = 1'b0;
        if (w_rd_done) begin
            rsp_valid[r_gnt] = 1'b1;
            rsp_rdata        = ctrl_rdata;
        end else if (w_wd_fire) begin
            rsp_valid[r_gnt] = 1'b1;
            rsp_rdata        = 32'hDEAD_BEEF;
        end
    end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: reset, writes, backpressure, read routing, fairness, reset mid-read, back-to-back reads.
module tb_sdram_req_arbiter;
    localparam int NREQ = 3, ADDR_W = 23, DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid, req_rw, req_busy, rsp_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]      rsp_rdata, ctrl_wdata, ctrl_rdata;
    logic                   ctrl_in_valid, ctrl_rw, ctrl_busy, ctrl_out_valid, timeout_err;
    logic [ADDR_W-1:0]      ctrl_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdram_req_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_busy(req_busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_busy(ctrl_busy), .ctrl_out_valid(ctrl_out_valid), .ctrl_rdata(ctrl_rdata),
        .timeout_err(timeout_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 3'b111; req_rw = 3'b111; req_addr = '1; req_wdata = '1;
        ctrl_busy = 1'b0; ctrl_out_valid = 1'b1; ctrl_rdata = 32'h0BAD_F00D;
        cyc(); cyc(); smp();
        n_tests++;
        if ({req_busy, rsp_valid, ctrl_in_valid} !== {3'b111, 3'b000, 1'b0}) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", {req_busy, rsp_valid, ctrl_in_valid}, 7'b1110000);
        end
        n_tests++;
        if ({ctrl_addr, ctrl_wdata, rsp_rdata, timeout_err} !== '0) begin
            n_fail++; $display("FAIL reset_dat: got %h/%h/%h/%b expected zeros", ctrl_addr, ctrl_wdata, rsp_rdata, timeout_err);
        end
        rst_n = 1'b1; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0; ctrl_out_valid = 1'b0;
        cyc();
    endtask

    task automatic test_single_write();
        req_valid = 3'b001; req_rw = 3'b001; req_addr[0 +: 23] = 23'h000010; req_wdata[0 +: 32] = 32'h1122_3344;
        smp();
        n_tests++;
        if ({ctrl_in_valid, req_busy} !== 4'b0111) begin
            n_fail++; $display("FAIL wr_arb_latency: got %b expected 0111", {ctrl_in_valid, req_busy});
        end
        cyc(); smp();
        n_tests++;
        if ({ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, req_busy} !== {1'b1, 1'b1, 23'h000010, 32'h1122_3344, 3'b110}) begin
            n_fail++; $display("FAIL wr_issue: got %b %b %h %h %b expected 1 1 000010 11223344 110",
                               ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, req_busy);
        end
        cyc(); req_valid = 3'b000; smp();
        n_tests++;
        if ({ctrl_in_valid, req_busy} !== 4'b0111) begin
            n_fail++; $display("FAIL wr_drop: got %b expected 0111", {ctrl_in_valid, req_busy});
        end
        cyc();
    endtask

    task automatic test_backpressure();
        req_valid = 3'b001; req_rw = 3'b001; req_addr[0 +: 23] = 23'h000020; req_wdata[0 +: 32] = 32'h5566_7788;
        ctrl_busy = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            smp();
            n_tests++;
            if ({ctrl_in_valid, ctrl_addr, ctrl_wdata, req_busy} !== {1'b1, 23'h000020, 32'h5566_7788, 3'b111}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got %b %h %h %b expected 1 000020 55667788 111",
                                   i, ctrl_in_valid, ctrl_addr, ctrl_wdata, req_busy);
            end
            cyc();
        end
        ctrl_busy = 1'b0; smp();
        n_tests++;
        if ({ctrl_in_valid, req_busy} !== 4'b1110) begin
            n_fail++; $display("FAIL bp_accept: got %b expected 1110", {ctrl_in_valid, req_busy});
        end
        cyc(); req_valid = 3'b000; cyc();
    endtask

    task automatic test_read_routing();
        req_valid = 3'b010; req_rw = 3'b000; req_addr[23 +: 23] = 23'h000100;
        cyc(); smp();
        n_tests++;
        if ({ctrl_in_valid, ctrl_rw, ctrl_addr, req_busy} !== {1'b1, 1'b0, 23'h000100, 3'b101}) begin
            n_fail++; $display("FAIL rd_issue: got %b %b %h %b expected 1 0 000100 101", ctrl_in_valid, ctrl_rw, ctrl_addr, req_busy);
        end
        cyc();
        req_valid = 3'b001; req_rw = 3'b001;
        for (int i = 0; i < 4; i++) begin
            smp();
            n_tests++;
            if ({ctrl_in_valid, req_busy, rsp_valid} !== 7'b0111000) begin
                n_fail++; $display("FAIL rd_wait[%0d]: got %b expected 0111000", i, {ctrl_in_valid, req_busy, rsp_valid});
            end
            cyc();
        end
        ctrl_out_valid = 1'b1; ctrl_rdata = 32'hCAFE_F00D; smp();
        n_tests++;
        if ({rsp_valid, rsp_rdata, ctrl_in_valid} !== {3'b010, 32'hCAFE_F00D, 1'b0}) begin
            n_fail++; $display("FAIL rd_route: got %b %h %b expected 010 cafef00d 0", rsp_valid, rsp_rdata, ctrl_in_valid);
        end
        cyc();
        req_valid = 3'b000; ctrl_rdata = 32'h1234_5678; smp();
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== 35'd0) begin
            n_fail++; $display("FAIL rd_stray_ignored: got %b %h expected 000 00000000", rsp_valid, rsp_rdata);
        end
        cyc(); ctrl_out_valid = 1'b0;
    endtask

    task automatic test_fairness();
        int          seq [4];
        logic [2:0]  eb;
        logic [22:0] ea;
        seq = '{0, 1, 2, 0};
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        req_valid = 3'b111; req_rw = 3'b111;
        for (int i = 0; i < 3; i++) begin
            req_addr[i*23 +: 23]  = 23'(32'h1000 * (i + 1));
            req_wdata[i*32 +: 32] = 32'hF000_0000 + i;
        end
        for (int g = 0; g < 4; g++) begin
            smp();
            n_tests++;
            if (ctrl_in_valid !== 1'b0) begin
                n_fail++; $display("FAIL fair_idle[%0d]: got %b expected 0", g, ctrl_in_valid);
            end
            cyc();
            eb = 3'b111; eb[seq[g]] = 1'b0;
            ea = 23'(32'h1000 * (seq[g] + 1));
            for (int b = 0; b < 8; b++) begin
                smp();
                n_tests++;
                if ({ctrl_in_valid, req_busy, ctrl_addr} !== {1'b1, eb, ea}) begin
                    n_fail++; $display("FAIL fair_grant[%0d.%0d]: got %b %b %h expected 1 %b %h", g, b, ctrl_in_valid, req_busy, ctrl_addr, eb, ea);
                end
                cyc();
            end
        end
        req_valid = 3'b000; smp();
        n_tests++;
        if (ctrl_in_valid !== 1'b0) begin
            n_fail++; $display("FAIL fair_end: got %b expected 0", ctrl_in_valid);
        end
        cyc();
    endtask

    task automatic test_reset_mid_read();
        req_valid = 3'b100; req_rw = 3'b000; req_addr[46 +: 23] = 23'h7FFFFF;
        cyc(); smp();
        n_tests++;
        if ({ctrl_in_valid, ctrl_addr, req_busy} !== {1'b1, 23'h7FFFFF, 3'b011}) begin
            n_fail++; $display("FAIL qs_issue: got %b %h %b expected 1 7fffff 011", ctrl_in_valid, ctrl_addr, req_busy);
        end
        cyc();
        req_valid = 3'b000; rst_n = 1'b0; smp();
        n_tests++;
        if ({ctrl_in_valid, req_busy} !== 4'b0111) begin
            n_fail++; $display("FAIL qs_wait: got %b expected 0111", {ctrl_in_valid, req_busy});
        end
        cyc();
        rst_n = 1'b1; ctrl_out_valid = 1'b1; ctrl_rdata = 32'h0BAD_CAFE; smp();
        n_tests++;
        if ({rsp_valid, rsp_rdata, req_busy, ctrl_in_valid, ctrl_addr} !== {3'b000, 32'h0, 3'b111, 1'b0, 23'h0}) begin
            n_fail++; $display("FAIL rst_abandon: got %b %h %b %b %h expected 000 00000000 111 0 000000",
                               rsp_valid, rsp_rdata, req_busy, ctrl_in_valid, ctrl_addr);
        end
        cyc(); ctrl_out_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        req_valid = 3'b011; req_rw = 3'b000; req_addr[0 +: 23] = 23'h000300; req_addr[23 +: 23] = 23'h000400;
        cyc(); smp();
        n_tests++;
        if ({ctrl_in_valid, ctrl_rw, ctrl_addr, req_busy} !== {1'b1, 1'b0, 23'h000300, 3'b110}) begin
            n_fail++; $display("FAIL b2b_rd1: got %b %b %h %b expected 1 0 000300 110", ctrl_in_valid, ctrl_rw, ctrl_addr, req_busy);
        end
        cyc();
        ctrl_out_valid = 1'b1; ctrl_rdata = 32'hA5A5_0001; smp();
        n_tests++;
        if ({rsp_valid, rsp_rdata, req_busy} !== {3'b001, 32'hA5A5_0001, 3'b111}) begin
            n_fail++; $display("FAIL b2b_rsp1: got %b %h %b expected 001 a5a50001 111", rsp_valid, rsp_rdata, req_busy);
        end
        cyc();
        ctrl_out_valid = 1'b0; req_addr[0 +: 23] = 23'h000301; smp();
        n_tests++;
        if ({ctrl_in_valid, ctrl_addr, req_busy} !== {1'b1, 23'h000301, 3'b110}) begin
            n_fail++; $display("FAIL b2b_rd2: got %b %h %b expected 1 000301 110", ctrl_in_valid, ctrl_addr, req_busy);
        end
        cyc();
        req_valid = 3'b010; ctrl_out_valid = 1'b1; ctrl_rdata = 32'hA5A5_0002; smp();
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {3'b001, 32'hA5A5_0002}) begin
            n_fail++; $display("FAIL b2b_rsp2: got %b %h expected 001 a5a50002", rsp_valid, rsp_rdata);
        end
        cyc();
        ctrl_out_valid = 1'b0; smp();
        n_tests++;
        if ({ctrl_in_valid, rsp_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_rearb: got %b expected 0000", {ctrl_in_valid, rsp_valid});
        end
        cyc(); smp();
        n_tests++;
        if ({ctrl_in_valid, ctrl_addr, req_busy} !== {1'b1, 23'h000400, 3'b101}) begin
            n_fail++; $display("FAIL b2b_mm_next: got %b %h %b expected 1 000400 101", ctrl_in_valid, ctrl_addr, req_busy);
        end
        cyc();
        req_valid = 3'b000; ctrl_out_valid = 1'b1; ctrl_rdata = 32'hA5A5_0003; smp();
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {3'b010, 32'hA5A5_0003}) begin
            n_fail++; $display("FAIL b2b_mm_rsp: got %b %h expected 010 a5a50003", rsp_valid, rsp_rdata);
        end
        cyc(); ctrl_out_valid = 1'b0; smp();
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err_idle: got %b expected 0", timeout_err);
        end
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        ctrl_busy = 1'b0; ctrl_out_valid = 1'b0; ctrl_rdata = '0;
        test_reset();
        test_single_write();
        test_backpressure();
        test_read_routing();
        test_fairness();
        test_reset_mid_read();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
